fsm_seq_monitor: RTL and testbench

Parametrised Moore-style protocol monitor for a two-wire control pair {i1,i2}. It walks IDLE through STEPS active steps and back to IDLE, with programmable per-step advance and error codes. It adds a per-step dwell timeout, an error-cause record, a saturating error counter and a completion pulse. It sits beside the control-path FSMs in the FPGA designs and flags protocol violations on the sampled pair.

---
 rtl/fsm_seq_monitor_pkg.sv | 17 +
 rtl/fsm_seq_monitor_if.sv | 27 ++
 rtl/fsm_seq_monitor_dwell_timer.sv | 20 ++
 rtl/fsm_seq_monitor.sv | 83 ++++++++
 tb/tb_fsm_seq_monitor.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fsm_seq_monitor_pkg.sv
// fsm_seq_pkg: shared cause codes, code-table access and step-width helper for the sequence monitor
package fsm_seq_pkg;
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_e;
  localparam int MAX_STEPS = 8;
  // Code tables are widened to the largest supported step count so one helper serves every configuration
  typedef logic [2*MAX_STEPS+1:0] code_tab_t;
  function automatic logic [1:0] code_at(input code_tab_t tbl, input int k);
    return tbl[2*k +: 2];
  endfunction
  function automatic int step_w(input int steps);
    return $clog2(steps + 2);
  endfunction
endpackage

// File: rtl/fsm_seq_monitor_if.sv
// fsm_seq_monitor_if: sampled control pair, controls and status outputs of the sequence monitor
import fsm_seq_pkg::*;
interface fsm_seq_monitor_if #(
  parameter int STEPS = 2,
  parameter int CNT_W = 8
);
  localparam int SW = step_w(STEPS);
  logic             en;
  logic             i1;
  logic             i2;
  logic             clr_err;
  logic [SW-1:0]    step;
  logic             busy;
  logic             err;
  logic             err_sticky;
  logic [1:0]       err_cause;
  logic [CNT_W-1:0] err_cnt;
  logic             done;
  modport master (
    output en, i1, i2, clr_err,
    input  step, busy, err, err_sticky, err_cause, err_cnt, done
  );
  modport slave (
    input  en, i1, i2, clr_err,
    output step, busy, err, err_sticky, err_cause, err_cnt, done
  );
endinterface

// File: rtl/fsm_seq_monitor_dwell_timer.sv
// seq_dwell_timer: per-step hold counter with a terminal flag at TIMEOUT-1 (never set when TIMEOUT=0)
module seq_dwell_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic en,
  output logic term
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [W-1:0] dwell_q, dwell_d;
  always_comb dwell_d = !en ? dwell_q : clr ? '0 : (inc && TIMEOUT != 0) ? dwell_q + 1'b1 : dwell_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) dwell_q <= '0;
    else dwell_q <= dwell_d;
  assign term = TIMEOUT != 0 && dwell_q == LAST;
endmodule

// File: rtl/fsm_seq_monitor.sv
// fsm_seq_monitor: Moore monitor walking IDLE -> steps 1..STEPS -> IDLE on {i1,i2}, flagging illegal codes and dwell timeouts
module fsm_seq_monitor
  import fsm_seq_pkg::*;
#(
  parameter int               STEPS     = 2,
  parameter logic [2*STEPS+1:0] ADV_CODES = 6'b10_11_11,
  parameter logic [2*STEPS+1:0] ERR_CODES = 6'b00_01_10,
  parameter int               TIMEOUT   = 16,
  parameter int               CNT_W     = 8
) (
  input logic              clk,
  input logic              rst,
  fsm_seq_monitor_if.slave bus
);
  localparam int SW = step_w(STEPS);
  localparam logic [SW-1:0] IDLE = '0;
  localparam logic [SW-1:0] LAST = SW'(STEPS);
  localparam logic [SW-1:0] ER   = SW'(STEPS + 1);
  localparam code_tab_t ADV  = code_tab_t'(ADV_CODES);
  localparam code_tab_t ERRT = code_tab_t'(ERR_CODES);
  logic [SW-1:0]    state_q, state_d;
  logic             done_q, done_d, sticky_q, sticky_d;
  logic [1:0]       cause_q, cause_d, cause_new, code;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             in_step, hold, enter, term;
  always_comb begin
    code      = {bus.i1, bus.i2};
    in_step   = state_q != IDLE && state_q <= LAST;
    state_d   = state_q;
    done_d    = 1'b0;
    cause_new = CAUSE_NONE;
    if (bus.en) begin
      if (state_q == ER) state_d = bus.i1 ? ER : IDLE;
      else if (state_q > ER) state_d = IDLE;
      else if (code == code_at(ADV, int'(state_q))) begin
        state_d = state_q == LAST ? IDLE : state_q + 1'b1;
        done_d  = state_q == LAST;
      end else if (code == code_at(ERRT, int'(state_q))) begin
        state_d   = ER;
        cause_new = CAUSE_ILLEGAL;
      end else if (in_step && term) begin
        state_d   = ER;
        cause_new = CAUSE_TIMEOUT;
      end
    end
    hold     = in_step && state_d == state_q;
    enter    = state_d == ER && state_q != ER;
    // A clear and an entry on the same edge: clear first, then count the entry
    cnt_base = bus.clr_err ? '0 : cnt_q;
    cnt_d    = (enter && ~&cnt_base) ? cnt_base + 1'b1 : cnt_base;
    sticky_d = enter || (sticky_q && !bus.clr_err);
    cause_d  = enter ? cause_new : bus.clr_err ? CAUSE_NONE : cause_q;
  end
  seq_dwell_timer #(.TIMEOUT(TIMEOUT)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_d != state_q),
    .inc  (hold),
    .en   (bus.en),
    .term (term)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      sticky_q <= 1'b0;
      cause_q  <= CAUSE_NONE;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      sticky_q <= sticky_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
    end
  assign bus.step       = state_q;
  assign bus.busy       = state_q != IDLE && state_q <= LAST;
  assign bus.err        = state_q == ER;
  assign bus.done       = done_q;
  assign bus.err_sticky = sticky_q;
  assign bus.err_cause  = cause_q;
  assign bus.err_cnt    = cnt_q;
endmodule

// File: tb/tb_fsm_seq_monitor.sv
// tb_fsm_seq_monitor: two monitor instances (TIMEOUT 16/CNT_W 8 and TIMEOUT 4/CNT_W 2) against a rule-level reference model
module tb_fsm_seq_monitor;
  localparam int STEPS = 2;
  localparam int ER    = STEPS + 1;
  int adv_t[3]   = '{3, 3, 2};
  int err_t[3]   = '{2, 1, 0};
  int to_lim[2]  = '{16, 4};
  int cnt_max[2] = '{255, 3};
  logic clk = 0, rst = 0, en = 0, i1 = 0, i2 = 0, clr = 0;
  int m_st[2], m_dw[2], m_cnt[2], m_sk[2], m_ca[2], m_dn[2];
  int n_chk = 0, n_err = 0;
  string phase = "reset";
  always #5 clk = ~clk;
  fsm_seq_monitor_if #(.STEPS(STEPS), .CNT_W(8)) b0 ();
  fsm_seq_monitor_if #(.STEPS(STEPS), .CNT_W(2)) b1 ();
  assign b0.en = en;
  assign b0.i1 = i1;
  assign b0.i2 = i2;
  assign b0.clr_err = clr;
  assign b1.en = en;
  assign b1.i1 = i1;
  assign b1.i2 = i2;
  assign b1.clr_err = clr;
  fsm_seq_monitor #(.STEPS(STEPS), .TIMEOUT(16), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  fsm_seq_monitor #(.STEPS(STEPS), .TIMEOUT(4), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s [%s] got %0d expected %0d at %0t", tag, phase, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_dw[i] = 0; m_cnt[i] = 0; m_sk[i] = 0; m_ca[i] = 0; m_dn[i] = 0;
    end
  endtask

  // One enabled-or-not clock edge, straight from the protocol rules
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int code, nd, ent, cs;
      code = int'({i1, i2});
      nd = 0; ent = 0; cs = 0;
      if (en) begin
        if (m_st[i] == ER) begin
          if (!i1) m_st[i] = 0;
        end else if (code == adv_t[m_st[i]]) begin
          nd = (m_st[i] == STEPS) ? 1 : 0;
          m_st[i] = nd ? 0 : m_st[i] + 1;
          m_dw[i] = 0;
        end else if (code == err_t[m_st[i]]) begin
          m_st[i] = ER; m_dw[i] = 0; ent = 1; cs = 1;
        end else if (m_st[i] != 0) begin
          if (to_lim[i] != 0 && m_dw[i] == to_lim[i] - 1) begin
            m_st[i] = ER; m_dw[i] = 0; ent = 1; cs = 2;
          end else m_dw[i]++;
        end
      end
      if (clr) begin m_cnt[i] = 0; m_sk[i] = 0; m_ca[i] = 0; end
      if (ent) begin
        if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        m_sk[i] = 1; m_ca[i] = cs;
      end
      m_dn[i] = nd;
    end
  endtask

  task automatic check_one(input int i, input logic [31:0] st, bz, er, sk, ca, cn, dn);
    string p;
    p = $sformatf("u%0d", i);
    chk({p, " step"}, st, m_st[i]);
    chk({p, " busy"}, bz, (m_st[i] >= 1 && m_st[i] <= STEPS) ? 1 : 0);
    chk({p, " err"}, er, (m_st[i] == ER) ? 1 : 0);
    chk({p, " err_sticky"}, sk, m_sk[i]);
    chk({p, " err_cause"}, ca, m_ca[i]);
    chk({p, " err_cnt"}, cn, m_cnt[i]);
    chk({p, " done"}, dn, m_dn[i]);
  endtask

  task automatic check_all();
    check_one(0, 32'(b0.step), 32'(b0.busy), 32'(b0.err), 32'(b0.err_sticky), 32'(b0.err_cause), 32'(b0.err_cnt), 32'(b0.done));
    check_one(1, 32'(b1.step), 32'(b1.busy), 32'(b1.err), 32'(b1.err_sticky), 32'(b1.err_cause), 32'(b1.err_cnt), 32'(b1.done));
  endtask

  task automatic tick(input logic e, input logic [1:0] c, input logic cl);
    en = e; {i1, i2} = c; clr = cl;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any clock edge
  task automatic do_reset();
    #2 rst = 0;
    model_reset();
    #1 check_all();
    @(negedge clk) rst = 1;
  endtask

  initial begin
    model_reset();
    #12 check_all();
    @(negedge clk) rst = 1;
    phase = "sequence";
    tick(1, 2'b00, 0); tick(1, 2'b11, 0); tick(1, 2'b00, 0);
    tick(1, 2'b11, 0); tick(1, 2'b01, 0); tick(1, 2'b10, 0);
    chk("seq done pulse", 32'(b0.done), 1);
    chk("seq step idle", 32'(b0.step), 0);
    tick(1, 2'b00, 0);
    chk("seq done one cycle", 32'(b0.done), 0);
    phase = "illegal";
    tick(1, 2'b10, 0);
    chk("ill step", 32'(b0.step), 3);
    chk("ill cause", 32'(b0.err_cause), 1);
    tick(1, 2'b10, 0); tick(1, 2'b11, 0); tick(1, 2'b10, 0);
    chk("ill stay er", 32'(b0.err), 1);
    tick(1, 2'b01, 0);
    chk("ill exit", 32'(b0.step), 0);
    chk("ill sticky", 32'(b0.err_sticky), 1);
    phase = "timeout";
    do_reset();
    tick(1, 2'b11, 0);
    repeat (4) tick(1, 2'b00, 0);
    chk("to err", 32'(b1.err), 1);
    chk("to cause", 32'(b1.err_cause), 2);
    chk("to long limit holds", 32'(b0.step), 1);
    phase = "timeout_adv";
    do_reset();
    tick(1, 2'b11, 0);
    repeat (3) tick(1, 2'b00, 0);
    tick(1, 2'b11, 0);
    chk("to adv step", 32'(b1.step), 2);
    repeat (3) tick(1, 2'b01, 0);
    chk("to dwell restart", 32'(b1.err), 0);
    tick(1, 2'b01, 0);
    chk("to s2 cause", 32'(b1.err_cause), 2);
    phase = "enable";
    do_reset();
    tick(1, 2'b11, 0);
    for (int k = 0; k < 5; k++) tick(0, (k % 2) ? 2'b10 : 2'b01, 0);
    chk("en frozen step", 32'(b1.step), 1);
    repeat (3) tick(1, 2'b00, 0);
    chk("en no progress", 32'(b1.err), 0);
    phase = "counter";
    do_reset();
    repeat (5) begin tick(1, 2'b10, 0); tick(1, 2'b00, 0); end
    chk("cnt saturate", 32'(b1.err_cnt), 3);
    chk("cnt wide", 32'(b0.err_cnt), 5);
    tick(1, 2'b00, 1);
    chk("clr cnt", 32'(b1.err_cnt), 0);
    chk("clr cause", 32'(b1.err_cause), 0);
    tick(1, 2'b10, 1);
    chk("clr+entry cnt", 32'(b1.err_cnt), 1);
    chk("clr+entry sticky", 32'(b1.err_sticky), 1);
    phase = "async_reset";
    do_reset();
    tick(1, 2'b11, 0); tick(1, 2'b11, 0);
    chk("pre reset s2", 32'(b0.step), 2);
    en = 1; {i1, i2} = 2'b10;
    do_reset();
    chk("rst step", 32'(b0.step), 0);
    chk("rst done", 32'(b0.done), 0);
    tick(1, 2'b11, 0);
    chk("post rst idle adv", 32'(b0.step), 1);
    phase = "random";
    do_reset();
    repeat (3000) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      tick($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 40) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
